// File: rtl/lsu_if.sv
// Request/response handshake and data-memory port bundle for the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mwr;
    logic        moe;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [31:0] mrd;

    // The unit itself: serves requests, masters the memory port.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mrd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mwr, moe, ma, mwd
    );

    // Surrounding logic: execute stage on the request side, memory on the bus side.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mrd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mwr, moe, ma, mwd
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one access at a time, sub-word stores by read-modify-write,
// load lane extraction with sign/zero extension, bad accesses never touch memory.
module lsu #(
    parameter logic [31:0] MAX_ADDR = 32'd127
) (
    input logic  clock,
    input logic  reset,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mwr_q, mwr_d;
    logic        moe_q, moe_d;
    logic [31:0] ma_q, ma_d;
    logic [31:0] mwd_q, mwd_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic        accept;
    logic        req_bad;

    function automatic logic access_error(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        bad = (addr > MAX_ADDR) || (size == 2'd3) ||
              ((size == 2'd1) && addr[0]) ||
              ((size == 2'd2) && (addr[1:0] != 2'b00));
        return bad;
    endfunction

    // Little-endian lane select, then extend the byte/half to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        logic [31:0]        result;
        shifted = word >> {lane, 3'b000};
        b       = signed'(shifted[7:0]);
        h       = signed'(shifted[15:0]);
        case (size)
            2'd0: begin
                ext    = b;
                result = sgn ? ext : {24'd0, shifted[7:0]};
            end
            2'd1: begin
                ext    = h;
                result = sgn ? ext : {16'd0, shifted[15:0]};
            end
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace the addressed byte/half of the old word, keep the rest.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] mask;
        mask = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (word & ~(mask << {lane, 3'b000})) | ((wdata & mask) << {lane, 3'b000});
    endfunction

    assign accept  = bus.req_valid && req_ready_q;
    assign req_bad = access_error(bus.req_addr, bus.req_size);

    // Next-state and next-output decode; memory strobes default low every cycle.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        lane_d       = lane_q;
        size_d       = size_q;
        we_d         = we_q;
        sgn_d        = sgn_q;
        wdata_d      = wdata_q;
        mwr_d        = 1'b0;
        moe_d        = 1'b0;
        ma_d         = 32'd0;
        mwd_d        = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lane_d       = bus.req_addr[1:0];
                    size_d       = bus.req_size;
                    we_d         = bus.req_we;
                    sgn_d        = bus.req_signed;
                    wdata_d      = bus.req_wdata;
                    req_ready_d  = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                    if (req_bad) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_we && (bus.req_size == 2'd2)) begin
                        state_d = WRITE;
                        mwr_d   = 1'b1;
                        ma_d    = {bus.req_addr[31:2], 2'b00};
                        mwd_d   = bus.req_wdata;
                    end else begin
                        state_d = READ;
                        moe_d   = 1'b1;
                        ma_d    = {bus.req_addr[31:2], 2'b00};
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    state_d = WRITE;
                    mwr_d   = 1'b1;
                    ma_d    = ma_q;
                    mwd_d   = store_merge(bus.mrd, wdata_q, lane_q, size_q);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extract(bus.mrd, lane_q, size_q, sgn_q);
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'd0;
            end
            default: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                end
            end
        endcase
    end

    // Control state and registered outputs; reset drops the memory strobes at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mwr_q        <= 1'b0;
            moe_q        <= 1'b0;
            ma_q         <= 32'd0;
            mwd_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mwr_q        <= mwr_d;
            moe_q        <= moe_d;
            ma_q         <= ma_d;
            mwd_q        <= mwd_d;
        end
    end

    // Latched request fields; only meaningful while a request is in flight.
    always_ff @(posedge clock) begin
        lane_q  <= lane_d;
        size_q  <= size_d;
        we_q    <= we_d;
        sgn_q   <= sgn_d;
        wdata_q <= wdata_d;
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mwr        = mwr_q;
    assign bus.moe        = moe_q;
    assign bus.ma         = ma_q;
    assign bus.mwd        = mwd_q;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: 128-byte word memory behind the unit, byte-level reference model.
module tb_lsu;
    logic clock;
    logic reset;
    lsu_if bus ();

    lsu #(.MAX_ADDR(32'd127)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int mwr_cnt = 0;
    int moe_cnt = 0;
    logic [31:0] mem [0:31];
    logic [7:0]  model_mem [0:127];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Data memory: combinational read, write on rising edge.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clock);
            if (bus.mwr === 1'b1) mem[bus.ma[6:2]] <= bus.mwd;
        end
    end
    assign bus.mrd = (bus.moe === 1'b1) ? mem[bus.ma[6:2]] : 32'd0;

    // Strobe activity counters.
    always @(posedge clock) begin
        if (bus.mwr === 1'b1) mwr_cnt++;
        if (bus.moe === 1'b1) moe_cnt++;
    end

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        if (a > 32'd127) return 1'b1;
        if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sgn);
        int n;
        logic [31:0] v;
        n = 1 << s;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(a) + i]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        for (int i = 0; i < (1 << s); i++) model_mem[int'(a) + i] = wd[8 * i +: 8];
    endtask

    // One full request/response exchange with resp_ready held high.
    task automatic txn(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clock);
        bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got=%b want=1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%b want=0", bus.resp_valid); end
        n_cmp++; if (bus.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_resp_rdata got=%h want=0", bus.resp_rdata); end
        n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp_err got=%b want=0", bus.resp_err); end
        n_cmp++; if (bus.mwr !== 1'b0 || bus.moe !== 1'b0) begin n_bad++; $display("FAIL rst_strobes got=%b%b want=00", bus.mwr, bus.moe); end
        n_cmp++; if (bus.ma !== 32'd0 || bus.mwd !== 32'd0) begin n_bad++; $display("FAIL rst_bus got=%h/%h want=0/0", bus.ma, bus.mwd); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic er;
        int lat, w0;
        w0 = mwr_cnt;
        txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        model_store(32'h10, 2'd2, 32'hDEADBEEF);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wstore_lat got=%0d want=2", lat); end
        n_cmp++; if (mwr_cnt - w0 !== 1) begin n_bad++; $display("FAIL wstore_mwr_cycles got=%0d want=1", mwr_cnt - w0); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'd0) begin n_bad++; $display("FAIL wstore_resp got=%b/%h want=0/0", er, rd); end
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL wload got=%h/%b want=deadbeef/0", rd, er); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wload_lat got=%0d want=2", lat); end
        txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5, rd, er, lat);
        model_store(32'h11, 2'd0, 32'hA5);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bstore_lat got=%0d want=3", lat); end
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADA5EF) begin n_bad++; $display("FAIL bstore_word got=%h want=deada5ef", rd); end
        txn(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFFFA5) begin n_bad++; $display("FAIL bload_s got=%h want=ffffffa5", rd); end
        txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h000000A5) begin n_bad++; $display("FAIL bload_u got=%h want=000000a5", rd); end
        txn(1'b1, 2'd1, 1'b0, 32'h12, 32'h00008234, rd, er, lat);
        model_store(32'h12, 2'd1, 32'h8234);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL hstore_lat got=%0d want=3", lat); end
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h8234A5EF) begin n_bad++; $display("FAIL hstore_word got=%h want=8234a5ef", rd); end
        txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFF8234) begin n_bad++; $display("FAIL hload_s got=%h want=ffff8234", rd); end
        txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h00008234) begin n_bad++; $display("FAIL hload_u got=%h want=00008234", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat, w0, o0;
        logic [31:0] ea [4];
        logic [1:0]  es [4];
        logic        ew [4];
        ea = '{32'h02, 32'h11, 32'h80, 32'h00};
        es = '{2'd2, 2'd1, 2'd2, 2'd3};
        ew = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            w0 = mwr_cnt; o0 = moe_cnt;
            txn(ew[k], es[k], 1'b0, ea[k], 32'h1234_5678, rd, er, lat);
            n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL err_resp[%0d] got=%b/%h want=1/0", k, er, rd); end
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL err_lat[%0d] got=%0d want=1", k, lat); end
            n_cmp++; if (mwr_cnt != w0 || moe_cnt != o0) begin n_bad++; $display("FAIL err_strobes[%0d] got=%0d/%0d want=0/0", k, mwr_cnt - w0, moe_cnt - o0); end
        end
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== model_load(32'h10, 2'd2, 1'b0)) begin n_bad++; $display("FAIL err_mem10 got=%h want=%h", rd, model_load(32'h10, 2'd2, 1'b0)); end
        txn(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== model_load(32'h00, 2'd2, 1'b0)) begin n_bad++; $display("FAIL err_mem00 got=%h want=%h", rd, model_load(32'h00, 2'd2, 1'b0)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, want;
        int n, o0;
        @(negedge clock);
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
        bus.req_addr = 32'h10; bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
        @(posedge clock);
        #1;
        bus.req_addr = 32'h14;
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL bp_lat got=%0d want=2", n); end
        rd = bus.resp_rdata;
        want = model_load(32'h10, 2'd2, 1'b0);
        n_cmp++; if (rd !== want) begin n_bad++; $display("FAIL bp_data got=%h want=%h", rd, want); end
        o0 = moe_cnt;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            n_cmp++; if (bus.resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", c, bus.resp_valid); end
            n_cmp++; if (bus.resp_rdata !== rd) begin n_bad++; $display("FAIL bp_hold_data[%0d] got=%h want=%h", c, bus.resp_rdata, rd); end
            n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready[%0d] got=%b want=0", c, bus.req_ready); end
        end
        n_cmp++; if (moe_cnt != o0) begin n_bad++; $display("FAIL bp_no_accept got=%0d want=0", moe_cnt - o0); end
        @(negedge clock);
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got=%b/%b want=0/1", bus.resp_valid, bus.req_ready); end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        want = model_load(32'h14, 2'd2, 1'b0);
        n_cmp++; if (bus.resp_rdata !== want) begin n_bad++; $display("FAIL bp_pending got=%h want=%h", bus.resp_rdata, want); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd, want;
        logic er;
        int lat, w0;
        w0 = mwr_cnt;
        @(negedge clock);
        bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'h10; bus.req_wdata = $urandom; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++; if (bus.mwr !== 1'b1) begin n_bad++; $display("FAIL mid_in_write got=%b want=1", bus.mwr); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.mwr !== 1'b0 || bus.moe !== 1'b0) begin n_bad++; $display("FAIL mid_strobes got=%b%b want=00", bus.mwr, bus.moe); end
        n_cmp++; if (bus.ma !== 32'd0 || bus.mwd !== 32'd0) begin n_bad++; $display("FAIL mid_bus got=%h/%h want=0/0", bus.ma, bus.mwd); end
        n_cmp++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL mid_resp got=%b/%b/%h want=0/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got=%b want=1", bus.req_ready); end
        n_cmp++; if (mwr_cnt != w0) begin n_bad++; $display("FAIL mid_no_write got=%0d want=0", mwr_cnt - w0); end
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        want = model_load(32'h10, 2'd2, 1'b0);
        n_cmp++; if (rd !== want) begin n_bad++; $display("FAIL mid_mem got=%h want=%h", rd, want); end
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] rd, addr, wd, want_rd;
        logic er, we, sgn, want_er;
        logic [1:0] size;
        int lat, w0, o0, want_lat, want_w, want_o;
        for (int t = 0; t < 80; t++) begin
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 139));
            if (size != 2'd3 && $urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << size) - 32'd1);
            we = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            wd = $urandom;
            want_er = model_err(addr, size);
            want_rd = (want_er || we) ? 32'd0 : model_load(addr, size, sgn);
            want_lat = want_er ? 1 : ((!we || size == 2'd2) ? 2 : 3);
            want_w = (we && !want_er) ? 1 : 0;
            want_o = (want_er || (we && size == 2'd2)) ? 0 : 1;
            w0 = mwr_cnt; o0 = moe_cnt;
            txn(we, size, sgn, addr, wd, rd, er, lat);
            if (we && !want_er) model_store(addr, size, wd);
            n_cmp++; if (er !== want_er) begin n_bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", t, er, want_er); end
            n_cmp++; if (rd !== want_rd) begin n_bad++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", t, rd, want_rd); end
            n_cmp++; if (lat !== want_lat) begin n_bad++; $display("FAIL rnd_lat[%0d] got=%0d want=%0d", t, lat, want_lat); end
            n_cmp++; if (mwr_cnt - w0 !== want_w) begin n_bad++; $display("FAIL rnd_mwr[%0d] got=%0d want=%0d", t, mwr_cnt - w0, want_w); end
            n_cmp++; if (moe_cnt - o0 !== want_o) begin n_bad++; $display("FAIL rnd_moe[%0d] got=%0d want=%0d", t, moe_cnt - o0, want_o); end
        end
        for (int i = 0; i < 32; i++) begin
            txn(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0, rd, er, lat);
            want_rd = model_load(32'(4 * i), 2'd2, 1'b0);
            n_cmp++; if (rd !== want_rd) begin n_bad++; $display("FAIL sweep[%0d] got=%h want=%h", i, rd, want_rd); end
        end
    endtask

    initial begin
        logic [31:0] w;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) model_mem[4 * i + b] = w[8 * b +: 8];
        end
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit that sits directly upstream of the data memory and is the only master of its `mwr`/`moe`/`ma`/`mwd` port. It accepts one load or store at a time from the execute stage over a valid/ready handshake. Sub-word stores are performed as read-modify-write over the memory's word-wide port, and loads are extracted and sign- or zero-extended. Misaligned and out-of-range accesses are rejected with an error response and never reach memory.

## Interface
- `MAX_ADDR`, 127: highest legal byte address; any `req_addr > MAX_ADDR` is an error.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as an error.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned, out-of-range or bad size.
- `mwr`  out  1  memory write enable, sampled by memory on rising edge.
- `moe`  out  1  memory output enable.
- `ma`  out  32  memory byte address, always word-aligned (`{addr[31:2],2'b00}`).
- `mwd`  out  32  memory write data.
- `mrd`  in  32  memory read data, combinational from `ma`/`moe`.

## Operation
- States: IDLE, READ, WRITE, RESP. Request fields are latched on accept (`req_valid && req_ready`).
- Error check on accept:
  - half with `addr[0]=1`: error.
  - word with `addr[1:0]!=0`: error.
  - `addr > MAX_ADDR`: error.
  - `size==3`: error.
  - On error: go IDLE→RESP with `resp_err=1`, no `moe`/`mwr` ever asserted.
- Load: IDLE→READ→RESP. In READ drive `ma` and `moe=1`, capture `mrd` at the cycle's closing edge.
- Word store: IDLE→WRITE→RESP. `mwd = wdata`.
- Byte/half store: IDLE→READ→WRITE→RESP. The READ capture is merged with the new data:
  - byte lane = `addr[1:0]`, replaces bits `[8*lane+7:8*lane]`.
  - half lane = `addr[1]`, replaces `[15:0]` or `[31:16]`.
  - other bits are preserved.
- Little-endian lane extraction for loads. Byte/half results are extended to 32 bits per `req_signed`; word loads ignore `req_signed`.
- RESP: `resp_valid=1` and `resp_rdata`/`resp_err` held stable until `resp_ready`. On `resp_valid && resp_ready` go to IDLE.
- Outputs by state:
  - `mwr=1` only in WRITE, for exactly one cycle per store.
  - `moe=1` only in READ.
  - `ma` is the latched aligned address in READ/WRITE and 0 otherwise.
  - `mwd` is 0 outside WRITE.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mwr=0`, `moe=0`, `ma=0`, `mwd=0`.
- `mwr`/`moe`/`ma`/`mwd` are decoded from state, so asserting `reset` deasserts `mwr` within the same cycle. A store interrupted in WRITE writes nothing.
- Latency from the accept edge to `resp_valid` high (with `resp_ready=1`):
  - error: 1 cycle.
  - load or word store: 2 cycles.
  - sub-word store: 3 cycles.
- Throughput: one request at a time. The earliest next accept is the edge after the RESP handshake, since `req_ready` rises in IDLE.
- A store's memory update is visible to a load accepted afterward; no forwarding is needed.

## Test plan
- Word store `0xDEADBEEF` @`0x10`, then word load @`0x10`: `mwr` high exactly 1 cycle, store `resp_valid` 2 cycles after accept, load returns `0xDEADBEEF`, `resp_err=0`.
- Byte store `0xA5` @`0x11`:
  - word load @`0x10` returns `0xDEADA5EF`.
  - signed byte load @`0x11` returns `0xFFFFFFA5`; unsigned returns `0x000000A5`.
  - store response 3 cycles after accept.
- Half store `0x8234` @`0x12`: word load @`0x10` returns `0x8234A5EF`. Signed half load @`0x12` returns `0xFFFF8234`; unsigned returns `0x00008234`.
- Word load @`0x02`, half store @`0x11`, and word store @`0x80`: each gives `resp_err=1` and `resp_rdata=0` 1 cycle after accept, with `mwr`/`moe` never asserted. Memory contents are unchanged.
- Hold `resp_ready=0` for 3 cycles after a load completes: `resp_valid`/`resp_rdata` stay stable, `req_ready` stays 0, and a pending `req_valid` is not accepted until the handshake.
- Assert `reset` mid-WRITE of a byte store @`0x10`: `mwr` drops in the same cycle, word @`0x10` is unchanged, all outputs are at reset values, and `req_ready=1` after release.
